// File: rtl/slot_buffer_ctrl_if.sv
// Write/read handshake and slot-steering signals of the four-slot buffer controller.
interface slot_buffer_ctrl_if #(
  parameter int unsigned DATA_W = 8
);
  logic              wr_valid;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ready;
  logic              rd_valid;
  logic              rd_ready;
  logic [DATA_W-1:0] rd_data;
  logic [1:0]        demux_sel;
  logic [3:0]        slot_we;

  // Producer/consumer side
  modport master (
    output wr_valid, wr_data, rd_ready,
    input  wr_ready, rd_valid, rd_data, demux_sel, slot_we
  );

  // Controller side
  modport slave (
    input  wr_valid, wr_data, rd_ready,
    output wr_ready, rd_valid, rd_data, demux_sel, slot_we
  );
endinterface

// File: rtl/slot_buffer_ctrl.sv
// Four-slot in-order byte buffer: steers writes through the demux select,
// returns bytes in arrival order and flags over/underflow attempts.
module slot_buffer_ctrl #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  slot_buffer_ctrl_if.slave bus,
  output logic [2:0]        count,
  output logic [1:0]        state,
  output logic              ovf_err,
  output logic              udf_err
);

  localparam int unsigned SLOTS = 4;
  localparam int unsigned CNT_W = 3;
  localparam int unsigned PTR_W = 2;

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'b00,
    ST_PARTIAL = 2'b01,
    ST_FULL    = 2'b10
  } state_e;

  state_e            state_q;
  state_e            state_nxt;
  logic [CNT_W-1:0]  count_nxt;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [DATA_W-1:0] slot_q [SLOTS];

  logic full_c;
  logic empty_c;
  logic wr_ready_c;
  logic rd_valid_c;
  logic wr_fire_c;
  logic rd_fire_c;

  // Handshake qualification; clear blocks writes for its cycle
  assign full_c     = (count == CNT_W'(SLOTS));
  assign empty_c    = (count == '0);
  assign wr_ready_c = ~full_c & ~clear;
  assign rd_valid_c = ~empty_c;
  assign wr_fire_c  = bus.wr_valid & wr_ready_c;
  assign rd_fire_c  = rd_valid_c & bus.rd_ready;

  // Combinational port views of pointer and slot state
  assign bus.wr_ready  = wr_ready_c;
  assign bus.rd_valid  = rd_valid_c;
  assign bus.demux_sel = wr_ptr;
  assign bus.slot_we   = wr_fire_c ? (4'b0001 << wr_ptr) : 4'b0000;
  assign bus.rd_data   = slot_q[rd_ptr];
  assign state         = state_q;

  // Next occupancy and the state it implies
  always_comb begin
    count_nxt = count;
    state_nxt = state_q;
    if (clear) begin
      count_nxt = '0;
    end else begin
      unique case ({wr_fire_c, rd_fire_c})
        2'b10:   count_nxt = CNT_W'(count + CNT_W'(1));
        2'b01:   count_nxt = CNT_W'(count - CNT_W'(1));
        default: count_nxt = count;
      endcase
    end
    if (count_nxt == '0) begin
      state_nxt = ST_EMPTY;
    end else if (count_nxt == CNT_W'(SLOTS)) begin
      state_nxt = ST_FULL;
    end else begin
      state_nxt = ST_PARTIAL;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_nxt;
    end
  end

  // Pointers, occupancy and sticky error flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      ovf_err <= 1'b0;
      udf_err <= 1'b0;
    end else if (clear) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      ovf_err <= 1'b0;
      udf_err <= 1'b0;
    end else begin
      count <= count_nxt;
      if (wr_fire_c) wr_ptr <= PTR_W'(wr_ptr + PTR_W'(1));
      if (rd_fire_c) rd_ptr <= PTR_W'(rd_ptr + PTR_W'(1));
      if (bus.wr_valid && full_c) ovf_err <= 1'b1;
      if (bus.rd_ready && empty_c) udf_err <= 1'b1;
    end
  end

  // Slot storage; contents survive clear but not reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q <= '{default: '0};
    end else if (wr_fire_c) begin
      slot_q[wr_ptr] <= bus.wr_data;
    end
  end

endmodule

// File: tb/tb_slot_buffer_ctrl.sv
// Directed vector bench for slot_buffer_ctrl.
module tb_slot_buffer_ctrl;

  localparam int unsigned DATA_W = 8;

  logic       clk;
  logic       rst_n;
  logic       clear;
  logic [2:0] count;
  logic [1:0] state;
  logic       ovf_err;
  logic       udf_err;

  slot_buffer_ctrl_if #(.DATA_W(DATA_W)) bif ();

  slot_buffer_ctrl #(.DATA_W(DATA_W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (clear),
    .bus     (bif),
    .count   (count),
    .state   (state),
    .ovf_err (ovf_err),
    .udf_err (udf_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       clr;
    logic       wv;
    logic [7:0] wd;
    logic       rr;
    logic       e_wrdy;
    logic       e_rv;
    logic [7:0] e_rd;
    logic [1:0] e_sel;
    logic [3:0] e_we;
    logic [2:0] e_cnt;
    logic [1:0] e_st;
    logic       e_ovf;
    logic       e_udf;
  } vec_t;

  vec_t vecs[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic void add(input logic clr, input logic wv, input logic [7:0] wd,
                              input logic rr, input logic wrdy, input logic rv,
                              input logic [7:0] rd, input logic [1:0] sel,
                              input logic [3:0] we, input logic [2:0] cnt,
                              input logic [1:0] st, input logic ovf, input logic udf);
    vec_t v;
    v.clr = clr; v.wv = wv; v.wd = wd; v.rr = rr;
    v.e_wrdy = wrdy; v.e_rv = rv; v.e_rd = rd; v.e_sel = sel; v.e_we = we;
    v.e_cnt = cnt; v.e_st = st; v.e_ovf = ovf; v.e_udf = udf;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic check_outputs(input int idx, input vec_t v);
    check("wr_ready",  idx, 32'(bif.wr_ready),  32'(v.e_wrdy));
    check("rd_valid",  idx, 32'(bif.rd_valid),  32'(v.e_rv));
    check("rd_data",   idx, 32'(bif.rd_data),   32'(v.e_rd));
    check("demux_sel", idx, 32'(bif.demux_sel), 32'(v.e_sel));
    check("slot_we",   idx, 32'(bif.slot_we),   32'(v.e_we));
    check("count",     idx, 32'(count),         32'(v.e_cnt));
    check("state",     idx, 32'(state),         32'(v.e_st));
    check("ovf_err",   idx, 32'(ovf_err),       32'(v.e_ovf));
    check("udf_err",   idx, 32'(udf_err),       32'(v.e_udf));
  endtask

  initial begin
    vec_t rv;
    // clr wv  wd    rr | wrdy rv rd    sel we       cnt st     ovf udf
    add(0, 0, 8'h00, 0,   1, 0, 8'h00, 0, 4'b0000, 0, 2'b00, 0, 0); // 0 reset idle
    add(0, 1, 8'h11, 0,   1, 0, 8'h00, 0, 4'b0001, 0, 2'b00, 0, 0); // 1
    add(0, 1, 8'h22, 0,   1, 1, 8'h11, 1, 4'b0010, 1, 2'b01, 0, 0); // 2
    add(0, 1, 8'h33, 0,   1, 1, 8'h11, 2, 4'b0100, 2, 2'b01, 0, 0); // 3
    add(0, 1, 8'h44, 0,   1, 1, 8'h11, 3, 4'b1000, 3, 2'b01, 0, 0); // 4
    add(0, 1, 8'h55, 0,   0, 1, 8'h11, 0, 4'b0000, 4, 2'b10, 0, 0); // 5 write while full
    add(0, 0, 8'h00, 0,   0, 1, 8'h11, 0, 4'b0000, 4, 2'b10, 1, 0); // 6 ovf, slot A kept
    add(0, 0, 8'h00, 1,   0, 1, 8'h11, 0, 4'b0000, 4, 2'b10, 1, 0); // 7 reads
    add(0, 0, 8'h00, 1,   1, 1, 8'h22, 0, 4'b0000, 3, 2'b01, 1, 0); // 8
    add(0, 0, 8'h00, 1,   1, 1, 8'h33, 0, 4'b0000, 2, 2'b01, 1, 0); // 9
    add(0, 0, 8'h00, 1,   1, 1, 8'h44, 0, 4'b0000, 1, 2'b01, 1, 0); // 10
    add(0, 0, 8'h00, 1,   1, 0, 8'h11, 0, 4'b0000, 0, 2'b00, 1, 0); // 11 read while empty
    add(0, 0, 8'h00, 0,   1, 0, 8'h11, 0, 4'b0000, 0, 2'b00, 1, 1); // 12
    add(1, 0, 8'h00, 0,   0, 0, 8'h11, 0, 4'b0000, 0, 2'b00, 1, 1); // 13 clear
    add(0, 0, 8'h00, 0,   1, 0, 8'h11, 0, 4'b0000, 0, 2'b00, 0, 0); // 14
    add(0, 1, 8'h11, 0,   1, 0, 8'h11, 0, 4'b0001, 0, 2'b00, 0, 0); // 15 wrap test
    add(0, 1, 8'h22, 0,   1, 1, 8'h11, 1, 4'b0010, 1, 2'b01, 0, 0); // 16
    add(0, 1, 8'h33, 0,   1, 1, 8'h11, 2, 4'b0100, 2, 2'b01, 0, 0); // 17
    add(0, 0, 8'h00, 1,   1, 1, 8'h11, 3, 4'b0000, 3, 2'b01, 0, 0); // 18
    add(0, 0, 8'h00, 1,   1, 1, 8'h22, 3, 4'b0000, 2, 2'b01, 0, 0); // 19
    add(0, 1, 8'hA0, 0,   1, 1, 8'h33, 3, 4'b1000, 1, 2'b01, 0, 0); // 20
    add(0, 1, 8'hA1, 0,   1, 1, 8'h33, 0, 4'b0001, 2, 2'b01, 0, 0); // 21 sel wrapped
    add(0, 1, 8'hA2, 0,   1, 1, 8'h33, 1, 4'b0010, 3, 2'b01, 0, 0); // 22
    add(0, 0, 8'h00, 1,   0, 1, 8'h33, 2, 4'b0000, 4, 2'b10, 0, 0); // 23
    add(0, 0, 8'h00, 1,   1, 1, 8'hA0, 2, 4'b0000, 3, 2'b01, 0, 0); // 24
    add(0, 1, 8'hB0, 1,   1, 1, 8'hA1, 2, 4'b0100, 2, 2'b01, 0, 0); // 25 simultaneous
    add(0, 1, 8'hB1, 1,   1, 1, 8'hA2, 3, 4'b1000, 2, 2'b01, 0, 0); // 26
    add(0, 1, 8'hB2, 1,   1, 1, 8'hB0, 0, 4'b0001, 2, 2'b01, 0, 0); // 27
    add(0, 1, 8'hB3, 1,   1, 1, 8'hB1, 1, 4'b0010, 2, 2'b01, 0, 0); // 28
    add(0, 1, 8'hB4, 1,   1, 1, 8'hB2, 2, 4'b0100, 2, 2'b01, 0, 0); // 29
    add(0, 1, 8'hC0, 0,   1, 1, 8'hB3, 3, 4'b1000, 2, 2'b01, 0, 0); // 30
    add(0, 1, 8'hC1, 0,   1, 1, 8'hB3, 0, 4'b0001, 3, 2'b01, 0, 0); // 31
    add(0, 1, 8'hC2, 1,   0, 1, 8'hB3, 1, 4'b0000, 4, 2'b10, 0, 0); // 32 full, both high
    add(0, 0, 8'h00, 0,   1, 1, 8'hB4, 1, 4'b0000, 3, 2'b01, 1, 0); // 33
    add(1, 0, 8'h00, 1,   0, 1, 8'hB4, 1, 4'b0000, 3, 2'b01, 1, 0); // 34 clear beats read
    add(0, 0, 8'h00, 0,   1, 0, 8'hC1, 0, 4'b0000, 0, 2'b00, 0, 0); // 35
    add(0, 1, 8'hD0, 1,   1, 0, 8'hC1, 0, 4'b0001, 0, 2'b00, 0, 0); // 36 empty, both high
    add(0, 0, 8'h00, 0,   1, 1, 8'hD0, 1, 4'b0000, 1, 2'b01, 0, 1); // 37

    rst_n        = 1'b0;
    clear        = 1'b0;
    bif.wr_valid = 1'b0;
    bif.wr_data  = '0;
    bif.rd_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      rv           = vecs[i];
      clear        = rv.clr;
      bif.wr_valid = rv.wv;
      bif.wr_data  = rv.wd;
      bif.rd_ready = rv.rr;
      #2;
      check_outputs(i, rv);
      @(negedge clk);
    end

    // Asynchronous reset between clock edges with one byte held
    clear        = 1'b0;
    bif.wr_valid = 1'b0;
    bif.rd_ready = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    check("async count",   100, 32'(count),         32'd0);
    check("async state",   100, 32'(state),         32'd0);
    check("async rd_valid",100, 32'(bif.rd_valid),  32'd0);
    check("async wr_ready",100, 32'(bif.wr_ready),  32'd1);
    check("async rd_data", 100, 32'(bif.rd_data),   32'd0);
    check("async sel",     100, 32'(bif.demux_sel), 32'd1 - 32'd1);
    check("async udf_err", 100, 32'(udf_err),       32'd0);
    #1;
    rst_n = 1'b1;

    // Post-reset write lands in slot A again
    @(negedge clk);
    bif.wr_valid = 1'b1;
    bif.wr_data  = 8'h5A;
    #2;
    check("post slot_we", 101, 32'(bif.slot_we), 32'h1);
    @(negedge clk);
    bif.wr_valid = 1'b0;
    #2;
    check("post rd_data", 102, 32'(bif.rd_data), 32'h5A);
    check("post count",   102, 32'(count),       32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
